// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: sequential 12-bit binary to 4-digit BCD converter.
// A value is accepted in IDLE, converted by twelve double-dabble steps
// (one per clock) in CONV, and offered with a valid/ready handshake in DONE.
// The digit outputs keep the last result until the next conversion completes.
module bcd_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  bcd0,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd3,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [27:0] work_r;
    logic [3:0]  cnt_r;
    logic [27:0] step_s;
    logic        last_step_s;

    logic        in_ready_s;
    logic        out_valid_s;
    logic        busy_s;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;

    logic [3:0]  bcd0_r;
    logic [3:0]  bcd1_r;
    logic [3:0]  bcd2_r;
    logic [3:0]  bcd3_r;

    // Add 3 to a digit that is 5 or more; the sum wraps within 4 bits.
    function automatic logic [3:0] adj_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // One double-dabble step: adjust all four digit fields from their
    // pre-add values, then shift the whole register left by one bit.
    function automatic logic [27:0] dd_step(input logic [27:0] w);
        logic [27:0] a;
        a = {adj_digit(w[27:24]), adj_digit(w[23:20]),
             adj_digit(w[19:16]), adj_digit(w[15:12]), w[11:0]};
        return {a[26:0], 1'b0};
    endfunction

    assign step_s      = dd_step(work_r);
    assign last_step_s = (cnt_r == 4'd11);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: accept in IDLE, count steps in CONV, handshake in DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flags can be registered
    // and still line up with the state they describe.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state_nxt_s)
            ST_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
            end
            ST_CONV: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b1;
            end
            ST_DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
                busy_s      = 1'b1;
            end
        endcase
    end

    // Registered handshake and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Conversion datapath: load on accept, step in CONV, capture digits on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= 28'd0;
            cnt_r  <= 4'd0;
            bcd0_r <= 4'd0;
            bcd1_r <= 4'd0;
            bcd2_r <= 4'd0;
            bcd3_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_r <= {16'd0, bin};
                        cnt_r  <= 4'd0;
                    end else begin
                        work_r <= work_r;
                        cnt_r  <= cnt_r;
                    end
                end
                ST_CONV: begin
                    work_r <= step_s;
                    cnt_r  <= cnt_r + 4'd1;
                    if (last_step_s) begin
                        bcd0_r <= step_s[15:12];
                        bcd1_r <= step_s[19:16];
                        bcd2_r <= step_s[23:20];
                        bcd3_r <= step_s[27:24];
                    end else begin
                        bcd0_r <= bcd0_r;
                        bcd1_r <= bcd1_r;
                        bcd2_r <= bcd2_r;
                        bcd3_r <= bcd3_r;
                    end
                end
                default: begin
                    work_r <= work_r;
                    cnt_r  <= cnt_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign bcd0      = bcd0_r;
    assign bcd1      = bcd1_r;
    assign bcd2      = bcd2_r;
    assign bcd3      = bcd3_r;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Testbench for bcd_seq_ctrl: expected digits and accept times are queued
// when an accept is driven and compared when out_valid rises.
module tb_bcd_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bcd0;
    logic [3:0]  bcd1;
    logic [3:0]  bcd2;
    logic [3:0]  bcd3;
    logic        busy;

    int          n_vec;
    int          n_err;
    int          cyc;
    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic [15:0] held;
    logic        prev_ov;

    bcd_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd0      (bcd0),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latency and accept intervals can be measured.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference digits {thousands, hundreds, tens, units} by decimal arithmetic.
    function automatic logic [15:0] exp_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int digits();
        return int'({bcd3, bcd2, bcd1, bcd0});
    endfunction

    // Scoreboard monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_flags", int'({in_ready, out_valid, busy}), 3'b100);
            check("rst_digits", digits(), 0);
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(exp_bcd(int'(bin)));
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    held = exp_q.pop_front();
                    check("result", digits(), int'(held));
                    check("latency", cyc - acc_q.pop_front(), 12);
                end
            end else if (out_valid) begin
                check("hold_stable", digits(), int'(held));
            end
            if (out_valid) begin
                check("in_ready_low_in_done", int'(in_ready), 0);
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid at a falling edge.
    task automatic wait_ov();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("timeout_out_valid", 0, 1);
    endtask

    // Wait (bounded) for the block to return to IDLE.
    task automatic wait_idle();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("timeout_idle", 0, 1);
    endtask

    // One conversion with out_ready held high; checks in_ready after the handshake.
    task automatic do_conv(input int v);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bin       = 12'(v);
        tick();
        in_valid  = 1'b0;
        wait_ov();
        tick();
        @(negedge clk);
        check("ready_after_hs", int'({in_ready, busy}), 2'b10);
    endtask

    int n_hi;
    int acc_prev;
    int acc_now;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        prev_ov   = 1'b0;
        held      = 16'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bin       = 12'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Basic conversions including the range extremes.
        do_conv(0);
        do_conv(4095);
        do_conv(1234);
        do_conv(999);

        // Back-pressure: hold the result for five extra cycles.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bin       = 12'd2048;
        tick();
        in_valid  = 1'b0;
        wait_ov();
        n_hi = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) n_hi++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        if (out_valid) n_hi++;
        check("bp_valid_cycles", n_hi, 6);
        wait_idle();

        // bin and in_valid changes during CONV must not disturb the result.
        in_valid = 1'b1;
        bin      = 12'd100;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        bin      = 12'd4095;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        wait_ov();
        repeat (6) @(negedge clk);
        check("no_second_conv", int'(busy), 0);

        // Continuous requests: accepts every 14 cycles.
        bin      = 12'd57;
        in_valid = 1'b1;
        acc_prev = 0;
        for (int i = 0; i < 3; i++) begin
            acc_now = -1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (in_ready) begin
                    acc_now = cyc + 1;
                    break;
                end
            end
            if (acc_now < 0) check("timeout_accept", 0, 1);
            else if (i > 0) check("accept_interval", acc_now - acc_prev, 14);
            acc_prev = acc_now;
            tick();
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a conversion abandons it.
        in_valid = 1'b1;
        bin      = 12'd500;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", int'({out_valid, busy}), 0);
        check("post_rst_digits", digits(), 0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("no_ov_after_rst", int'(out_valid), 0);
        end
        do_conv(321);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
